// File: rtl/decompression_engine.sv
// Rebuilds a 128-bit cache line from MSB-first variable-length codes, using a 16-entry FIFO dictionary.
// Latency: a compressed line decodes one word per cycle and is ready 4 cycles after acceptance; a raw line is ready 1 cycle after.
// Backpressure: the result is held in DONE until i_ready; o_ready is high only in IDLE, so one line is in flight at a time.
module decompression_engine #(
  parameter int CACHE_LINE = 128,
  parameter int WORD       = 32,
  parameter int DICT_ENTRY = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [CACHE_LINE-1:0]        i_line,
  input  logic                         i_raw,
  input  logic                         i_dict_clear,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [CACHE_LINE-1:0]        o_line,
  output logic                         o_error,
  output logic [DICT_ENTRY*WORD-1:0]   o_dictionary_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [127:0]  shreg_q, shreg_d;   // unparsed bits, next code always at bit 127
  logic [7:0]    ptr_q, ptr_d;       // bits consumed so far in this line
  logic [1:0]    wcnt_q, wcnt_d;     // word slot being decoded
  logic [127:0]  line_q, line_d;
  logic          err_q, err_d;

  logic [31:0]   dict_q [16];
  logic [3:0]    wr_ptr_q;

  logic [5:0]    code_len;
  logic [31:0]   code_word;
  logic          code_push;
  logic          code_illegal;
  logic [3:0]    idx_short;
  logic [3:0]    idx_long;
  logic [31:0]   ent_short;
  logic [31:0]   ent_long;
  logic [8:0]    ptr_sum;
  logic          overrun;
  logic          push_en;
  logic          clr_en;

  // Index position depends on prefix length: 2-bit prefixes put it at 125, 4-bit prefixes at 123.
  assign idx_short = shreg_q[125:122];
  assign idx_long  = shreg_q[123:120];
  assign ent_short = dict_q[idx_short];
  assign ent_long  = dict_q[idx_long];

  // Decode the code sitting at the top of the shift register.
  always_comb begin
    code_len     = 6'd2;
    code_word    = 32'h0;
    code_push    = 1'b0;
    code_illegal = 1'b0;
    case (shreg_q[127:126])
      2'b00: begin
        code_len = 6'd2;
      end
      2'b01: begin
        code_len  = 6'd34;
        code_word = shreg_q[125:94];
        code_push = 1'b1;
      end
      2'b10: begin
        code_len  = 6'd6;
        code_word = ent_short;
      end
      default: begin
        case (shreg_q[125:124])
          2'b00: begin
            code_len  = 6'd24;
            code_word = {ent_long[31:16], shreg_q[119:104]};
            code_push = 1'b1;
          end
          2'b01: begin
            code_len  = 6'd12;
            code_word = {24'h0, shreg_q[123:116]};
          end
          2'b10: begin
            code_len  = 6'd16;
            code_word = {ent_long[31:8], shreg_q[119:112]};
            code_push = 1'b1;
          end
          default: begin
            code_len     = 6'd4;
            code_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // A code that reaches past bit 128 is decoded from zero fill but flagged.
  assign ptr_sum = {1'b0, ptr_q} + {3'b000, code_len};
  assign overrun = (ptr_sum > 9'd128);

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    line_d  = line_q;
    err_d   = err_q;
    push_en = 1'b0;
    clr_en  = 1'b0;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        clr_en  = i_dict_clear;
        if (i_valid) begin
          err_d = 1'b0;
          if (i_raw) begin
            line_d  = i_line;
            state_d = S_DONE;
          end else begin
            shreg_d = i_line;
            ptr_d   = 8'd0;
            wcnt_d  = 2'd0;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        case (wcnt_q)
          2'd0:    line_d[127:96] = code_word;
          2'd1:    line_d[95:64]  = code_word;
          2'd2:    line_d[63:32]  = code_word;
          default: line_d[31:0]   = code_word;
        endcase
        shreg_d = shreg_q << code_len;
        ptr_d   = ptr_sum[7:0];
        if (overrun || code_illegal) begin
          err_d = 1'b1;
        end
        push_en = code_push & ~overrun;
        wcnt_d  = wcnt_q + 2'd1;
        if (wcnt_q == 2'd3) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Parse and result registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      shreg_q <= '0;
      ptr_q   <= '0;
      wcnt_q  <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

  // FIFO dictionary: clear wins (only possible in IDLE, where no push happens), else push at wr_ptr.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < 16; k++) begin
        dict_q[k] <= '0;
      end
      wr_ptr_q <= '0;
    end else if (clr_en) begin
      for (int k = 0; k < 16; k++) begin
        dict_q[k] <= '0;
      end
      wr_ptr_q <= '0;
    end else if (push_en) begin
      dict_q[wr_ptr_q] <= code_word;
      wr_ptr_q         <= wr_ptr_q + 4'd1;
    end
  end

  // Flatten the dictionary for external cross-checking.
  always_comb begin
    o_dictionary_data = '0;
    for (int k = 0; k < 16; k++) begin
      o_dictionary_data[32*k +: 32] = dict_q[k];
    end
  end

  assign o_line  = line_q;
  assign o_error = err_q;

endmodule
